// File: rtl/fb_scanout_arbiter_if.sv
// Host-side access port of the framebuffer/SPRAM arbiter.
// host_req is held with stable payload until a cycle where host_ready is high; that cycle is the transfer.
// Writes commit in the transfer cycle. For reads, host_rvalid pulses the following cycle with host_rdata.
interface fb_scanout_arbiter_if;
    logic        host_req;
    logic        host_we;
    logic [13:0] host_addr;
    logic [15:0] host_wdata;
    logic [3:0]  host_mask;
    logic        host_ready;
    logic [15:0] host_rdata;
    logic        host_rvalid;

    modport master (
        output host_req, host_we, host_addr, host_wdata, host_mask,
        input  host_ready, host_rdata, host_rvalid
    );

    modport slave (
        input  host_req, host_we, host_addr, host_wdata, host_mask,
        output host_ready, host_rdata, host_rvalid
    );
endinterface

// File: rtl/fb_scanout_arbiter.sv
// Shares one 16K x 16 SPRAM between 160x120x4bpp VGA scanout and a host port.
// Video owns ph==12 of each fetch column; the host gets every other cycle.
module fb_scanout_arbiter #(
    parameter logic [13:0] FB_BASE = 14'd0
) (
    input  logic                       i_clk_25mhz,
    input  logic                       i_resetn,
    input  logic [9:0]                 i_hpos,
    input  logic [9:0]                 i_vpos,
    input  logic                       i_display_valid,
    output logic [13:0]                o_spram_addr,
    output logic [15:0]                o_spram_wdata,
    output logic [3:0]                 o_spram_maskwren,
    output logic                       o_spram_wren,
    input  logic [15:0]                i_spram_rdata,
    fb_scanout_arbiter_if.slave        host_bus,
    output logic [3:0]                 o_pixel,
    output logic                       o_pixel_valid
);

    logic [5:0]  w_col;
    logic [3:0]  w_ph;
    logic [9:0]  w_vn;
    logic        w_cur_slot;
    logic        w_next_slot;
    logic        w_video_slot;
    logic [6:0]  w_fy;
    logic [5:0]  w_vcol;
    logic [13:0] w_vaddr;
    logic        w_host_ready;
    logic        w_host_rvalid;

    logic [13:0] r_addr_hold;
    logic        r_vid_rd;
    logic        r_host_rd;
    logic [15:0] r_pend_word;
    logic [15:0] r_cur_word;
    logic [15:0] r_rdata_hold;
    logic [3:0]  r_pixel;
    logic        r_pixel_valid;

    assign w_col = i_hpos[9:4];
    assign w_ph  = i_hpos[3:0];
    assign w_vn  = (i_vpos == 10'd524) ? 10'd0 : i_vpos + 10'd1;

    // Columns 1..39 of this line are fetched one column ahead; column 0 of the
    // next line is fetched in the last column of horizontal blanking.
    assign w_cur_slot   = (w_ph == 4'd12) && (w_col <= 6'd38) && (i_vpos < 10'd480);
    assign w_next_slot  = (w_ph == 4'd12) && (w_col == 6'd49) && (w_vn < 10'd480);
    assign w_video_slot = w_cur_slot | w_next_slot;

    assign w_fy    = w_next_slot ? w_vn[8:2] : i_vpos[8:2];
    assign w_vcol  = w_next_slot ? 6'd0 : w_col + 6'd1;
    // fy*40 = fy*32 + fy*8; the sum wraps at 14 bits.
    assign w_vaddr = FB_BASE + {2'b00, w_fy, 5'b00000} + {4'b0000, w_fy, 3'b000}
                   + {8'h00, w_vcol};

    assign w_host_ready  = i_resetn & host_bus.host_req & ~w_video_slot;
    assign w_host_rvalid = i_resetn & r_host_rd;

    always_comb begin
        o_spram_addr     = r_addr_hold;
        o_spram_wdata    = 16'h0000;
        o_spram_maskwren = 4'b0000;
        o_spram_wren     = 1'b0;
        if (i_resetn && w_video_slot) begin
            o_spram_addr = w_vaddr;
        end else if (w_host_ready) begin
            o_spram_addr = host_bus.host_addr;
            if (host_bus.host_we) begin
                o_spram_wren     = 1'b1;
                o_spram_maskwren = host_bus.host_mask;
                o_spram_wdata    = host_bus.host_wdata;
            end
        end
    end

    always_ff @(posedge i_clk_25mhz) begin
        if (!i_resetn) begin
            r_addr_hold   <= 14'd0;
            r_vid_rd      <= 1'b0;
            r_host_rd     <= 1'b0;
            r_pend_word   <= 16'h0000;
            r_cur_word    <= 16'h0000;
            r_rdata_hold  <= 16'h0000;
            r_pixel       <= 4'h0;
            r_pixel_valid <= 1'b0;
        end else begin
            r_addr_hold <= o_spram_addr;
            r_vid_rd    <= w_video_slot;
            r_host_rd   <= w_host_ready & ~host_bus.host_we;
            if (r_vid_rd) begin
                r_pend_word <= i_spram_rdata;
            end
            if (w_ph == 4'd15) begin
                r_cur_word <= r_pend_word;
            end
            if (r_host_rd) begin
                r_rdata_hold <= i_spram_rdata;
            end
            // Each nibble covers 4 display pixels; nibble [3:0] is leftmost.
            r_pixel       <= i_display_valid ? r_cur_word[{i_hpos[3:2], 2'b00} +: 4] : 4'h0;
            r_pixel_valid <= i_display_valid;
        end
    end

    assign host_bus.host_ready  = w_host_ready;
    assign host_bus.host_rvalid = w_host_rvalid;
    assign host_bus.host_rdata  = w_host_rvalid ? i_spram_rdata : r_rdata_hold;
    assign o_pixel              = r_pixel;
    assign o_pixel_valid        = r_pixel_valid;

endmodule

// File: tb/tb_fb_scanout_arbiter.sv
// Directed bench for fb_scanout_arbiter: vector table for slot/arbitration decode,
// hand-written sequences for reset, host read/write, masking and scanout.
module tb_fb_scanout_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [9:0]  hpos;
    logic [9:0]  vpos;
    logic        display_valid;
    logic [13:0] spram_addr;
    logic [15:0] spram_wdata;
    logic [3:0]  spram_maskwren;
    logic        spram_wren;
    logic [15:0] spram_rdata;
    logic [3:0]  pixel;
    logic        pixel_valid;

    int n_pass;
    int n_total;

    always #5 clk = ~clk;

    fb_scanout_arbiter_if host_if ();

    fb_scanout_arbiter #(.FB_BASE(14'd0)) dut (
        .i_clk_25mhz      (clk),
        .i_resetn         (resetn),
        .i_hpos           (hpos),
        .i_vpos           (vpos),
        .i_display_valid  (display_valid),
        .o_spram_addr     (spram_addr),
        .o_spram_wdata    (spram_wdata),
        .o_spram_maskwren (spram_maskwren),
        .o_spram_wren     (spram_wren),
        .i_spram_rdata    (spram_rdata),
        .host_bus         (host_if),
        .o_pixel          (pixel),
        .o_pixel_valid    (pixel_valid)
    );

    // SPRAM model: nibble-masked write, registered read.
    logic [15:0] mem [0:16383];
    always @(posedge clk) begin
        if (spram_wren) begin
            for (int n = 0; n < 4; n++) begin
                if (spram_maskwren[n]) mem[spram_addr][n*4 +: 4] <= spram_wdata[n*4 +: 4];
            end
        end
        spram_rdata <= mem[spram_addr];
    end

    typedef struct packed {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        req;
        logic        we;
        logic [13:0] a;
        logic [15:0] d;
        logic [3:0]  m;
        logic        exp_ready;
        logic        exp_wren;
        logic [3:0]  exp_mask;
        logic [13:0] exp_addr;
    } vec_t;

    vec_t       vecs [0:12];
    logic [3:0] exp_pix [0:35];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic set_pos(input logic [9:0] h, input logic [9:0] v);
        hpos = h;
        vpos = v;
        display_valid = (h < 10'd640) && (v < 10'd480);
    endtask

    task automatic adv_pos();
        if (hpos == 10'd799) set_pos(10'd0, (vpos == 10'd524) ? 10'd0 : vpos + 10'd1);
        else set_pos(hpos + 10'd1, vpos);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1 in a cycle with no video slot; returns at posedge+1.
    task automatic do_write(input logic [13:0] a, input logic [15:0] d, input logic [3:0] m);
        host_if.host_req   = 1'b1;
        host_if.host_we    = 1'b1;
        host_if.host_addr  = a;
        host_if.host_wdata = d;
        host_if.host_mask  = m;
        next_cycle();
        host_if.host_req = 1'b0;
        host_if.host_we  = 1'b0;
    endtask

    task automatic do_read(input logic [13:0] a, output logic [15:0] d, output logic v);
        host_if.host_req  = 1'b1;
        host_if.host_we   = 1'b0;
        host_if.host_addr = a;
        next_cycle();
        host_if.host_req = 1'b0;
        #4;
        v = host_if.host_rvalid;
        d = host_if.host_rdata;
        next_cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        logic        rv;
        n_pass = 0;
        n_total = 0;

        vecs[0]  = '{10'd12,  10'd0,   1'b1, 1'b1, 14'd100,  16'h1234, 4'hF, 1'b0, 1'b0, 4'h0, 14'd1};
        vecs[1]  = '{10'd11,  10'd0,   1'b1, 1'b1, 14'd100,  16'h1234, 4'hF, 1'b1, 1'b1, 4'hF, 14'd100};
        vecs[2]  = '{10'd620, 10'd477, 1'b0, 1'b0, 14'd0,    16'h0000, 4'h0, 1'b0, 1'b0, 4'h0, 14'd4799};
        vecs[3]  = '{10'd636, 10'd477, 1'b1, 1'b0, 14'd50,   16'h0000, 4'hF, 1'b1, 1'b0, 4'h0, 14'd50};
        vecs[4]  = '{10'd796, 10'd524, 1'b1, 1'b1, 14'd7,    16'h5555, 4'hF, 1'b0, 1'b0, 4'h0, 14'd0};
        vecs[5]  = '{10'd796, 10'd479, 1'b1, 1'b1, 14'd7,    16'h5555, 4'h3, 1'b1, 1'b1, 4'h3, 14'd7};
        vecs[6]  = '{10'd796, 10'd3,   1'b0, 1'b0, 14'd0,    16'h0000, 4'h0, 1'b0, 1'b0, 4'h0, 14'd40};
        vecs[7]  = '{10'd12,  10'd480, 1'b1, 1'b0, 14'd33,   16'h0000, 4'hF, 1'b1, 1'b0, 4'h0, 14'd33};
        vecs[8]  = '{10'd780, 10'd100, 1'b1, 1'b1, 14'd1234, 16'hBEEF, 4'h5, 1'b1, 1'b1, 4'h5, 14'd1234};
        vecs[9]  = '{10'd28,  10'd9,   1'b1, 1'b1, 14'd77,   16'h0001, 4'hF, 1'b0, 1'b0, 4'h0, 14'd82};
        vecs[10] = '{10'd796, 10'd477, 1'b0, 1'b0, 14'd0,    16'h0000, 4'h0, 1'b0, 1'b0, 4'h0, 14'd4760};
        vecs[11] = '{10'd604, 10'd477, 1'b1, 1'b0, 14'd9,    16'h0000, 4'h0, 1'b0, 1'b0, 4'h0, 14'd4798};
        vecs[12] = '{10'd13,  10'd477, 1'b0, 1'b0, 14'd9,    16'h0000, 4'h0, 1'b0, 1'b0, 4'h0, 14'd4798};

        // Line 0: words 16'h4321, 16'hFEDC, 16'h8765, leftmost nibble first.
        for (int i = 0; i < 4; i++) begin
            exp_pix[i]      = 4'h1; exp_pix[4 + i]  = 4'h2; exp_pix[8 + i]  = 4'h3; exp_pix[12 + i] = 4'h4;
            exp_pix[16 + i] = 4'hC; exp_pix[20 + i] = 4'hD; exp_pix[24 + i] = 4'hE; exp_pix[28 + i] = 4'hF;
            exp_pix[32 + i] = 4'h5;
        end

        // Reset with a pending host write and visible timing.
        resetn = 1'b0;
        host_if.host_req   = 1'b1;
        host_if.host_we    = 1'b1;
        host_if.host_addr  = 14'd3;
        host_if.host_wdata = 16'hFFFF;
        host_if.host_mask  = 4'hF;
        set_pos(10'd5, 10'd10);
        repeat (4) next_cycle();
        #4;
        chk("rst_ready", {15'd0, host_if.host_ready}, 16'd0);
        chk("rst_wren", {15'd0, spram_wren}, 16'd0);
        chk("rst_mask", {12'd0, spram_maskwren}, 16'd0);
        chk("rst_pixel", {12'd0, pixel}, 16'd0);
        chk("rst_pixel_valid", {15'd0, pixel_valid}, 16'd0);
        chk("rst_rvalid", {15'd0, host_if.host_rvalid}, 16'd0);
        chk("rst_rdata", host_if.host_rdata, 16'd0);
        next_cycle();
        resetn = 1'b1;
        host_if.host_req = 1'b0;
        host_if.host_we  = 1'b0;

        // Slot decode, address math and arbitration vectors.
        for (int i = 0; i < 13; i++) begin
            next_cycle();
            set_pos(vecs[i].h, vecs[i].v);
            host_if.host_req   = vecs[i].req;
            host_if.host_we    = vecs[i].we;
            host_if.host_addr  = vecs[i].a;
            host_if.host_wdata = vecs[i].d;
            host_if.host_mask  = vecs[i].m;
            #4;
            chk($sformatf("v%0d_ready", i), {15'd0, host_if.host_ready}, {15'd0, vecs[i].exp_ready});
            chk($sformatf("v%0d_wren", i), {15'd0, spram_wren}, {15'd0, vecs[i].exp_wren});
            chk($sformatf("v%0d_mask", i), {12'd0, spram_maskwren}, {12'd0, vecs[i].exp_mask});
            chk($sformatf("v%0d_addr", i), {2'd0, spram_addr}, {2'd0, vecs[i].exp_addr});
        end
        next_cycle();
        host_if.host_req = 1'b0;
        host_if.host_we  = 1'b0;
        set_pos(10'd0, 10'd500);
        next_cycle();

        // Continuous host write stream across a slot.
        do_write(14'd2012, 16'h0BAD, 4'hF);
        for (int h = 8; h <= 16; h++) begin
            set_pos(h[9:0], 10'd200);
            host_if.host_req   = 1'b1;
            host_if.host_we    = 1'b1;
            host_if.host_addr  = 14'd2000 + h[13:0];
            host_if.host_wdata = 16'hC000 + h[15:0];
            host_if.host_mask  = 4'hF;
            #4;
            chk($sformatf("stream_ready_h%0d", h), {15'd0, host_if.host_ready}, (h == 12) ? 16'd0 : 16'd1);
            chk($sformatf("stream_wren_h%0d", h), {15'd0, spram_wren}, (h == 12) ? 16'd0 : 16'd1);
            next_cycle();
        end
        host_if.host_req = 1'b0;
        host_if.host_we  = 1'b0;
        set_pos(10'd0, 10'd500);
        do_read(14'd2008, rd, rv);
        chk("stream_rd2008", rd, 16'hC008);
        do_read(14'd2012, rd, rv);
        chk("stream_rd2012", rd, 16'h0BAD);
        do_read(14'd2016, rd, rv);
        chk("stream_rd2016", rd, 16'hC010);

        // Host read-back and a read straddling a video slot.
        do_write(14'd9000, 16'hA5A5, 4'hF);
        do_read(14'd9000, rd, rv);
        chk("read_rvalid", {15'd0, rv}, 16'd1);
        chk("read_rdata", rd, 16'hA5A5);
        chk("read_rvalid_clear", {15'd0, host_if.host_rvalid}, 16'd0);
        set_pos(10'd11, 10'd300);
        host_if.host_req  = 1'b1;
        host_if.host_we   = 1'b0;
        host_if.host_addr = 14'd9000;
        #4;
        chk("slotread_ready_h11", {15'd0, host_if.host_ready}, 16'd1);
        next_cycle();
        host_if.host_req = 1'b0;
        set_pos(10'd12, 10'd300);
        #4;
        chk("slotread_rvalid_h12", {15'd0, host_if.host_rvalid}, 16'd1);
        chk("slotread_rdata_h12", host_if.host_rdata, 16'hA5A5);
        chk("slotread_vaddr_h12", {2'd0, spram_addr}, 16'd3001);
        next_cycle();
        set_pos(10'd13, 10'd300);
        #4;
        chk("slotread_rvalid_h13", {15'd0, host_if.host_rvalid}, 16'd0);
        next_cycle();

        // Nibble mask.
        set_pos(10'd0, 10'd500);
        do_write(14'd500, 16'h0000, 4'hF);
        do_write(14'd500, 16'hFFFF, 4'b0101);
        do_read(14'd500, rd, rv);
        chk("mask_rdata", rd, 16'h0F0F);

        // Scanout of the top-left words, with a host write right after a fetch.
        do_write(14'd0, 16'h4321, 4'hF);
        do_write(14'd1, 16'hFEDC, 4'hF);
        do_write(14'd2, 16'h8765, 4'hF);
        set_pos(10'd790, 10'd524);
        while (!(vpos == 10'd0 && hpos == 10'd37)) begin
            if (vpos == 10'd0 && hpos == 10'd29) begin
                host_if.host_req   = 1'b1;
                host_if.host_we    = 1'b1;
                host_if.host_addr  = 14'd2;
                host_if.host_wdata = 16'h1111;
                host_if.host_mask  = 4'hF;
            end else begin
                host_if.host_req = 1'b0;
                host_if.host_we  = 1'b0;
            end
            #4;
            if (vpos == 10'd524 && hpos == 10'd795)
                chk("scan_blank_valid", {15'd0, pixel_valid}, 16'd0);
            if (vpos == 10'd0 && hpos >= 10'd1) begin
                chk($sformatf("scan_pix_h%0d", hpos - 10'd1), {12'd0, pixel}, {12'd0, exp_pix[hpos - 10'd1]});
                chk($sformatf("scan_valid_h%0d", hpos - 10'd1), {15'd0, pixel_valid}, 16'd1);
            end
            next_cycle();
            adv_pos();
        end
        host_if.host_req = 1'b0;
        host_if.host_we  = 1'b0;
        set_pos(10'd0, 10'd500);
        do_read(14'd2, rd, rv);
        chk("scan_late_write_landed", rd, 16'h1111);

        // A read accepted just before reset must not produce rvalid.
        host_if.host_req  = 1'b1;
        host_if.host_we   = 1'b0;
        host_if.host_addr = 14'd9000;
        next_cycle();
        resetn = 1'b0;
        host_if.host_req = 1'b0;
        #4;
        chk("rst_kills_read_rvalid", {15'd0, host_if.host_rvalid}, 16'd0);
        next_cycle();
        resetn = 1'b1;
        #4;
        chk("after_rst_rvalid", {15'd0, host_if.host_rvalid}, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
